multicycle_seq_ctrl: RTL

- Multi-cycle sequencer for the RV32I subset datapath: R-type, I-ALU, lw, sw, beq/bne/blt/bge, jal, jalr, lui.
- Steps each instruction through fetch, decode, execute, memory and writeback.
- Uses req/ack handshakes to variable-latency instruction and data memories.
- Emits the one-cycle register-enable strobes (IR, PC, RF, ALU-out, MDR) that let a single shared ALU/memory datapath run one instruction at a time; static mux selects stay with the opcode decoder.

---
 rtl/multicycle_seq_ctrl.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_seq_ctrl.sv
// Multi-cycle control sequencer for an RV32I-subset datapath. It walks each instruction
// through IF/ID/EX/MEM/WB and issues one-cycle register-enable strobes to a shared datapath.
module multicycle_seq_ctrl #(
   parameter int CNT_W = 32
) (
   input  logic             cpu_clk,
   input  logic             cpu_rst,
   input  logic [6:0]       opcode,
   input  logic             branch_taken,
   input  logic             irom_ack,
   input  logic             dram_ack,
   output logic             irom_req,
   output logic             dram_req,
   output logic             dram_we,
   output logic             ir_we,
   output logic             ab_we,
   output logic             aluo_we,
   output logic             mdr_we,
   output logic             rf_we,
   output logic             pc_we,
   output logic             pc_tgt,
   output logic             illegal,
   output logic [2:0]       state_o,
   output logic [CNT_W-1:0] instret
);

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_IF   = 3'd1,
      ST_ID   = 3'd2,
      ST_EX   = 3'd3,
      ST_MEM  = 3'd4,
      ST_WB   = 3'd5,
      ST_TRAP = 3'd7
   } state_t;

   typedef enum logic [2:0] {
      CL_R     = 3'd0,
      CL_IALU  = 3'd1,
      CL_LOAD  = 3'd2,
      CL_STORE = 3'd3,
      CL_BR    = 3'd4,
      CL_JAL   = 3'd5,
      CL_JALR  = 3'd6,
      CL_LUI   = 3'd7
   } class_t;

   localparam logic [6:0] OPC_R     = 7'b0110011;
   localparam logic [6:0] OPC_IALU  = 7'b0010011;
   localparam logic [6:0] OPC_LOAD  = 7'b0000011;
   localparam logic [6:0] OPC_STORE = 7'b0100011;
   localparam logic [6:0] OPC_BR    = 7'b1100011;
   localparam logic [6:0] OPC_JAL   = 7'b1101111;
   localparam logic [6:0] OPC_JALR  = 7'b1100111;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;

   state_t           state_q, state_d;
   class_t           class_q, class_d;
   logic             illegal_q, illegal_d;
   logic [CNT_W-1:0] instret_q;
   class_t           dec_class;
   logic             dec_valid;

   always_comb begin
      dec_valid = 1'b1;
      dec_class = CL_R;
      case (opcode)
         OPC_R:     dec_class = CL_R;
         OPC_IALU:  dec_class = CL_IALU;
         OPC_LOAD:  dec_class = CL_LOAD;
         OPC_STORE: dec_class = CL_STORE;
         OPC_BR:    dec_class = CL_BR;
         OPC_JAL:   dec_class = CL_JAL;
         OPC_JALR:  dec_class = CL_JALR;
         OPC_LUI:   dec_class = CL_LUI;
         default:   dec_valid = 1'b0;
      endcase
   end

   // Next state; acks are only looked at inside their own request window.
   always_comb begin
      state_d   = state_q;
      class_d   = class_q;
      illegal_d = illegal_q;
      case (state_q)
         ST_IDLE: state_d = ST_IF;
         ST_IF: begin
            if (irom_ack) state_d = ST_ID;
         end
         ST_ID: begin
            if (dec_valid) begin
               class_d = dec_class;
               state_d = ST_EX;
            end else begin
               illegal_d = 1'b1;
               state_d   = ST_TRAP;
            end
         end
         ST_EX: begin
            case (class_q)
               CL_BR:             state_d = ST_IF;
               CL_LOAD, CL_STORE: state_d = ST_MEM;
               default:           state_d = ST_WB;
            endcase
         end
         ST_MEM: begin
            if (dram_ack) state_d = (class_q == CL_LOAD) ? ST_WB : ST_IF;
         end
         ST_WB:   state_d = ST_IF;
         ST_TRAP: state_d = ST_TRAP;
         default: state_d = ST_IDLE;
      endcase
   end

   // Strobes are decoded from the current state so each lands in exactly one cycle.
   always_comb begin
      irom_req = 1'b0;
      dram_req = 1'b0;
      dram_we  = 1'b0;
      ir_we    = 1'b0;
      ab_we    = 1'b0;
      aluo_we  = 1'b0;
      mdr_we   = 1'b0;
      rf_we    = 1'b0;
      pc_we    = 1'b0;
      pc_tgt   = 1'b0;
      case (state_q)
         ST_IF: begin
            irom_req = 1'b1;
            ir_we    = irom_ack;
         end
         ST_ID: ab_we = 1'b1;
         ST_EX: begin
            aluo_we = 1'b1;
            if (class_q == CL_BR) begin
               pc_we  = 1'b1;
               pc_tgt = branch_taken;
            end
         end
         ST_MEM: begin
            dram_req = 1'b1;
            dram_we  = (class_q == CL_STORE);
            mdr_we   = dram_ack && (class_q == CL_LOAD);
            pc_we    = dram_ack && (class_q == CL_STORE);
         end
         ST_WB: begin
            rf_we  = 1'b1;
            pc_we  = 1'b1;
            pc_tgt = (class_q == CL_JAL) || (class_q == CL_JALR);
         end
         default: ;
      endcase
   end

   always_ff @(posedge cpu_clk or posedge cpu_rst) begin
      if (cpu_rst) begin
         state_q   <= ST_IDLE;
         class_q   <= CL_R;
         illegal_q <= 1'b0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         illegal_q <= illegal_d;
         if (pc_we) instret_q <= instret_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
   end

   assign illegal = illegal_q;
   assign state_o = state_q;
   assign instret = instret_q;

endmodule
